dbi_rx8: RTL and testbench

Receiving end of the 8-bit inverting header link on the ice40 board. The sender drives the header pins with each byte either true or bit-inverted and flags the choice on an inversion line. `dbi_rx8` takes each word from the asynchronous header pins using a two-phase toggle handshake. It undoes the inversion, buffers the decoded byte in a small FIFO and presents it on a valid/ready stream to on-chip logic.

---
 rtl/dbi_rx8_pkg.sv | 26 ++
 rtl/dbi_rx8_fifo.sv | 91 +++++++++
 rtl/dbi_rx8.sv | 136 +++++++++++++
 tb/tb_dbi_rx8.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dbi_rx8_pkg.sv
// dbi_rx8_pkg: shared types and helpers for the inverting header link receiver.
//   DATA_W      - payload width
//   state_t     - receive FSM state
//   decode()    - undo the sender's optional bitwise inversion
//   parity_ok() - even parity over the wire bits (used when DBI_RX8_PARITY_EN is defined)
package dbi_rx8_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] decode(input logic [DATA_W-1:0] data,
                                                 input logic              inv);
        return inv ? ~data : data;
    endfunction

    function automatic logic parity_ok(input logic [DATA_W-1:0] data,
                                       input logic              inv,
                                       input logic              par);
        return ~(^{data, inv, par});
    endfunction

endpackage

// File: rtl/dbi_rx8_fifo.sv
// dbi_rx8_fifo: synchronous FIFO, DEPTH words x DATA_W, with a registered head.
//   clk, rst    - clock, async active-high reset
//   push, din   - write din when not full
//   pop         - drop head when not empty
//   full, empty - count-based status (registered)
//   head        - registered copy of the oldest word
module dbi_rx8_fifo
    import dbi_rx8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d, rd_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_push, do_pop;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign head   = head_q;
    assign rd_nxt = rd_q + AW'(1);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        do_push = push & ~full;
        do_pop  = pop & ~empty;

        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_nxt;
        end

        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Head only moves on a pop or on a write into an empty FIFO. When the
        // last word is popped while a new one arrives, the new word becomes head.
        if (do_pop) begin
            if (cnt_q > CW'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (do_push) begin
                head_d = din;
            end
        end else if (do_push && empty) begin
            head_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/dbi_rx8.sv
// dbi_rx8: receiver for the 8-bit inverting header link. Takes each word on a
// two-phase RX_REQ/RX_ACK toggle handshake, undoes the inversion and buffers the
// byte in a FIFO presented as a valid/ready stream.
//   CLK, RESET       - clock, async active-high reset
//   RX_DATA, RX_INV  - header data and inversion flag (held while request pending)
//   RX_REQ / RX_ACK  - toggle handshake with the sender
//   O, O_VALID, O_READY - output stream
//   RX_PAR, PERR     - only with DBI_RX8_PARITY_EN defined: wire parity bit and
//                      sticky parity error flag; bad words are acked and dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; accepts it at once if FIFO has room
// ST_STALL | request pending but FIFO full; ack withheld until room
module dbi_rx8
    import dbi_rx8_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_INV,
    input  logic              RX_REQ,
    output logic              RX_ACK,
    output logic [DATA_W-1:0] O,
    output logic              O_VALID,
    input  logic              O_READY
`ifdef DBI_RX8_PARITY_EN
    ,
    input  logic              RX_PAR,
    output logic              PERR
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    state_t                 state_q, state_d;
    logic                   req_sync, pending, word_good;
    logic                   fifo_push, fifo_full, fifo_empty;

`ifdef DBI_RX8_PARITY_EN
    logic perr_q, perr_d;
    assign word_good = parity_ok(RX_DATA, RX_INV, RX_PAR);
    assign PERR      = perr_q;
`else
    assign word_good = 1'b1;
`endif

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], RX_REQ};
    assign req_sync = sync_q[SYNC_STAGES-1];
    assign pending  = req_sync ^ req_seen_q;
    assign RX_ACK   = ack_q;
    assign O_VALID  = ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        req_seen_d = req_seen_q;
        fifo_push  = 1'b0;
`ifdef DBI_RX8_PARITY_EN
        perr_d     = perr_q;
`endif
        if (pending && !word_good) begin
            // Corrupt word: release the sender without storing anything,
            // regardless of FIFO occupancy.
            ack_d      = ~ack_q;
            req_seen_d = req_sync;
            state_d    = ST_IDLE;
`ifdef DBI_RX8_PARITY_EN
            perr_d     = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        if (!fifo_full) begin
                            fifo_push  = 1'b1;
                            ack_d      = ~ack_q;
                            req_seen_d = req_sync;
                        end else begin
                            state_d = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (pending && !fifo_full) begin
                        fifo_push  = 1'b1;
                        ack_d      = ~ack_q;
                        req_seen_d = req_sync;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            state_q    <= ST_IDLE;
`ifdef DBI_RX8_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            state_q    <= state_d;
`ifdef DBI_RX8_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    // Full comes from the registered count, so a same-cycle pop never makes
    // room for a push in that cycle.
    dbi_rx8_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (fifo_push),
        .pop   (O_READY),
        .din   (decode(RX_DATA, RX_INV)),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (O)
    );

endmodule

// File: tb/tb_dbi_rx8.sv
module tb_dbi_rx8;

    logic       CLK;
    logic       RESET;
    logic [7:0] RX_DATA;
    logic       RX_INV;
    logic       RX_REQ;
    logic       RX_ACK;
    logic [7:0] O;
    logic       O_VALID;
    logic       O_READY;
`ifdef DBI_RX8_PARITY_EN
    logic       RX_PAR;
    logic       PERR;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       inv;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    dbi_rx8 #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .RX_DATA (RX_DATA),
        .RX_INV  (RX_INV),
        .RX_REQ  (RX_REQ),
        .RX_ACK  (RX_ACK),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY)
`ifdef DBI_RX8_PARITY_EN
        ,
        .RX_PAR  (RX_PAR),
        .PERR    (PERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a word, toggle RX_REQ, wait up to budget edges for the ack.
    // lat = number of edges until ack seen, or -1 if it never came.
    task automatic send_word(input logic [7:0] d, input logic i, input int budget,
                             output int l);
        RX_DATA = d;
        RX_INV  = i;
        RX_REQ  = ~RX_REQ;
        l = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (RX_ACK == RX_REQ) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic drain(input int cycles);
        got_q.delete();
        for (int k = 0; k < cycles; k++) begin
            if (O_VALID && O_READY) got_q.push_back(O);
            step();
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, inv: 1'b0, exp: 8'hA5};
        vecs[1] = '{data: 8'h0F, inv: 1'b1, exp: 8'hF0};
        vecs[2] = '{data: 8'hFF, inv: 1'b1, exp: 8'h00};
        vecs[3] = '{data: 8'h00, inv: 1'b0, exp: 8'h00};
        vecs[4] = '{data: 8'h3C, inv: 1'b1, exp: 8'hC3};
        vecs[5] = '{data: 8'h80, inv: 1'b0, exp: 8'h80};

        RESET   = 1'b1;
        RX_DATA = 8'h00;
        RX_INV  = 1'b0;
        RX_REQ  = 1'b0;
        O_READY = 1'b1;
`ifdef DBI_RX8_PARITY_EN
        RX_PAR  = 1'b0;
`endif
        #3;
        chk("reset_ack", RX_ACK, 0);
        chk("reset_valid", O_VALID, 0);
        chk("reset_o", O, 8'h00);
        step();
        step();
        RESET = 1'b0;
        step();

        // Single words through an empty FIFO with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].data, vecs[v].inv, 6, lat);
            chk($sformatf("vec%0d_ack_latency", v), lat, 3);
            chk($sformatf("vec%0d_valid", v), O_VALID, 1);
            chk($sformatf("vec%0d_o", v), O, vecs[v].exp);
            step();
            chk($sformatf("vec%0d_valid_drop", v), O_VALID, 0);
            chk($sformatf("vec%0d_o_hold", v), O, vecs[v].exp);
        end

        // Backpressure: four words fill the FIFO, the fifth stalls.
        O_READY = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            send_word(8'(w), 1'b0, 6, lat);
            chk($sformatf("bp_word%0d_ack", w), lat, 3);
        end
        chk("bp_head", O, 8'h01);
        chk("bp_valid", O_VALID, 1);
        send_word(8'h05, 1'b0, 10, lat);
        chk("bp_fifth_no_ack", lat, -1);
        chk("bp_head_held", O, 8'h01);
        O_READY = 1'b1;
        drain(14);
        chk("bp_fifth_acked", RX_ACK, RX_REQ);
        chk("bp_count", got_q.size(), 5);
        for (int w = 0; w < 5; w++) begin
            if (w < got_q.size()) chk($sformatf("bp_order%0d", w), got_q[w], 8'(w + 1));
        end

        // Push and pop in the same edge at count 2.
        O_READY = 1'b0;
        send_word(8'h11, 1'b0, 6, lat);
        chk("pp_ack11", lat, 3);
        send_word(8'h22, 1'b0, 6, lat);
        chk("pp_ack22", lat, 3);
        RX_DATA = 8'h33;
        RX_INV  = 1'b0;
        RX_REQ  = ~RX_REQ;
        step();
        step();
        chk("pp_no_ack_yet", RX_ACK == RX_REQ, 0);
        O_READY = 1'b1;
        step();
        O_READY = 1'b0;
        chk("pp_ack33", RX_ACK, RX_REQ);
        chk("pp_head", O, 8'h22);
        chk("pp_valid", O_VALID, 1);
        O_READY = 1'b1;
        drain(6);
        chk("pp_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("pp_first", got_q[0], 8'h22);
            chk("pp_second", got_q[1], 8'h33);
        end

        // Reset with three words buffered and a request in flight.
        O_READY = 1'b0;
        send_word(8'h44, 1'b0, 6, lat);
        send_word(8'h55, 1'b0, 6, lat);
        send_word(8'h66, 1'b0, 6, lat);
        chk("rst_pre_ack", lat, 3);
        RX_DATA = 8'h77;
        RX_REQ  = ~RX_REQ;
        step();
        #2;
        RESET  = 1'b1;
        RX_REQ = 1'b0;
        #1;
        chk("rst_async_valid", O_VALID, 0);
        chk("rst_async_ack", RX_ACK, 0);
        chk("rst_async_o", O, 8'h00);
        step();
        RESET   = 1'b0;
        O_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rst_no_stale%0d", k), O_VALID, 0);
        end
        send_word(8'h5A, 1'b0, 6, lat);
        chk("rst_after_ack", lat, 3);
        chk("rst_after_o", O, 8'h5A);
        step();

`ifdef DBI_RX8_PARITY_EN
        O_READY = 1'b0;
        chk("par_perr_init", PERR, 0);
        RX_PAR = 1'b1;
        send_word(8'h03, 1'b0, 6, lat);
        chk("par_bad_ack", lat, 3);
        step();
        chk("par_bad_not_pushed", O_VALID, 0);
        chk("par_perr_set", PERR, 1);
        RX_PAR = 1'b0;
        send_word(8'h03, 1'b0, 6, lat);
        chk("par_good_ack", lat, 3);
        chk("par_good_valid", O_VALID, 1);
        chk("par_good_o", O, 8'h03);
        chk("par_perr_sticky", PERR, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
